prbs_chk_multi: RTL and testbench
=================================

Name: prbs_chk_multi

Overview:
- Parallel, multi-polynomial PRBS checker; successor to the single-bit, fixed-type PRBS receiver.
- Accepts DATA_W bits per valid cycle and checks them against a polynomial selected at runtime.
- Lock FSM: self-synchronising hunt, then free-running reference LFSR once locked.
- Provides saturating bit/error counters, a per-bit error mask and a loss-of-lock counter. Sits after the CDC FIFO on the receive clock.

Parameters:
DATA_W, 8, bits checked per valid cycle (1..32)
BIT_CNT_WIDTH, 32, width of bit_cnt
ERR_CNT_WIDTH, 32, width of err_cnt
LOCK_CNT, 4, consecutive clean words in HUNT required to lock (1..255)
UNLOCK_CNT, 4, consecutive errored words in LOCKED that drop lock (1..255)

Ports:
clk  in  1  checker clock
rst  in  1  asynchronous, active-high reset
poly_sel  in  3  0=PRBS7 x^7+x^6+1, 1=PRBS9 x^9+x^5+1, 2=PRBS15 x^15+x^14+1, 3=PRBS23 x^23+x^18+1, 4=PRBS31 x^31+x^28+1, 5..7 = PRBS7
cnt_clr  in  1  synchronous clear of bit_cnt, err_cnt, lock_loss_cnt and both full flags
din_vld  in  1  din valid this cycle
din  in  DATA_W  received bits; din[DATA_W-1] is the earliest bit in time
locked  out  1  FSM in LOCKED
err_vld  out  1  err_mask/err_word valid (registered din_vld)
err_mask  out  DATA_W  per-bit mismatch flags, same bit order as din
err_word  out  1  OR of err_mask
bit_cnt  out  BIT_CNT_WIDTH  bits checked while LOCKED, saturating
bit_cnt_full  out  1  bit_cnt reached all-ones
err_cnt  out  ERR_CNT_WIDTH  mismatched bits while LOCKED, saturating
err_cnt_full  out  1  err_cnt reached all-ones
lock_loss_cnt  out  8  LOCKED->HUNT transitions, saturating at 255

Behaviour:
- Reset (async): all outputs 0, FSM=HUNT, history and LFSR 0, hist_fill=0, run counters 0.
- Recurrence for poly x^n+x^m+1: b[k] = b[k-n] XOR b[k-m].
- History: 31-bit shift register of received bits, updated only on din_vld, DATA_W bits per word in time order. hist_fill counts accepted bits and saturates at 31.
- HUNT:
  - Predict each bit from received history, including earlier bits of the same word.
  - A word is "clean" only if hist_fill >= n before the word and no mismatch occurs.
  - clean: run+1; errored: run=0.
  - When run reaches LOCK_CNT, go to LOCKED next cycle. The reference LFSR is seeded with the last n received bits of that word.
  - In HUNT, err_mask is still reported (self-sync result); counters do not change.
- LOCKED:
  - Reference LFSR advances DATA_W steps per valid word. err_mask[i] = din[i] XOR predicted bit.
  - One flipped bit gives exactly one error.
  - bit_cnt += DATA_W and err_cnt += popcount(err_mask), both saturating at all-ones with the matching full flag set.
  - Errored word: bad+1; clean word: bad=0.
  - When bad reaches UNLOCK_CNT, go to HUNT. This increments lock_loss_cnt and clears run and hist_fill.
  - The word that triggers unlock is still counted.
- din_vld=0: no state advances, err_vld=0, err_mask holds.
- Latency: err_vld/err_mask/err_word and counter updates appear 1 cycle after the din_vld cycle. locked rises 1 cycle after the locking word is sampled.
- poly_sel: if it changes on any cycle (registered compare), force HUNT and clear run, bad and hist_fill. This is not counted as loss of lock. The word sampled that cycle is ignored for checking.
- cnt_clr with a simultaneous count update: clear wins, so counters read 0 next cycle. Lock state is unaffected.
- All-zero stream never locks, because the seeded LFSR would be zero: zero history counts as errored in HUNT.
- rst mid-operation returns to the reset state immediately; lock_loss_cnt is not incremented.

Test Plan:
- DATA_W=8, PRBS7 clean stream, continuous din_vld, LOCK_CNT=4 → locked=1 on the cycle after the 5th word (1 word fills history, then 4 clean words); err_cnt=0; bit_cnt=800 after 100 further words.
- While locked, flip din[3] in one word → err_mask=8'h08 for exactly one err_vld cycle; err_cnt=1; locked stays 1.
- Corrupt 4 consecutive words (UNLOCK_CNT=4) → locked=0 after the 4th; lock_loss_cnt=1; relock after 5 clean words; err_cnt includes all 4 words' mismatches.
- PRBS31 stream, din_vld toggling 50% → lock and zero errors; bit_cnt increments only on valid words; switching poly_sel to PRBS15 mid-stream → locked=0 immediately, lock_loss_cnt unchanged.
- BIT_CNT_WIDTH=10, ERR_CNT_WIDTH=4, inverted stream after lock → err_cnt sticks at 15 with err_cnt_full=1; bit_cnt sticks at 1023 with bit_cnt_full=1; cnt_clr → both 0, flags 0.
- Async rst asserted mid-LOCKED between clock edges → all outputs 0 before the next edge; an all-zero din stream afterwards never asserts locked.

Source files
------------

// File: rtl/prbs_chk_multi.sv
// prbs_chk_multi
//   Parallel PRBS checker with a runtime-selectable polynomial. Each valid
//   word carries DATA_W received bits (din[DATA_W-1] earliest). While hunting,
//   every bit is predicted from the received history itself (self-sync). After
//   LOCK_CNT consecutive clean words, a free-running reference LFSR takes over.
//   UNLOCK_CNT consecutive errored words drop lock again.
//
// Ports
//   clk, rst        checker clock, asynchronous active-high reset
//   poly_sel        0=PRBS7 1=PRBS9 2=PRBS15 3=PRBS23 4=PRBS31 5..7=PRBS7
//   cnt_clr         synchronous clear of the counters and full flags
//   din_vld, din    received word and its qualifier
//   locked          checker is in LOCKED
//   err_vld         err_mask/err_word valid (one cycle after din_vld)
//   err_mask        per-bit mismatch flags, same bit order as din
//   err_word        OR of err_mask
//   bit_cnt(_full)  bits checked while locked, saturating
//   err_cnt(_full)  mismatched bits while locked, saturating
//   lock_loss_cnt   LOCKED->HUNT transitions, saturating at 255
module prbs_chk_multi #(
    parameter int DATA_W        = 8,
    parameter int BIT_CNT_WIDTH = 32,
    parameter int ERR_CNT_WIDTH = 32,
    parameter int LOCK_CNT      = 4,
    parameter int UNLOCK_CNT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               poly_sel,
    input  logic                     cnt_clr,
    input  logic                     din_vld,
    input  logic [DATA_W-1:0]        din,
    output logic                     locked,
    output logic                     err_vld,
    output logic [DATA_W-1:0]        err_mask,
    output logic                     err_word,
    output logic [BIT_CNT_WIDTH-1:0] bit_cnt,
    output logic                     bit_cnt_full,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     err_cnt_full,
    output logic [7:0]               lock_loss_cnt
);

    // Adder widths: at least one bit wider than both the counter and the
    // largest increment (32), so overflow shows up in the top bits.
    localparam int BSW = ((BIT_CNT_WIDTH > 6) ? BIT_CNT_WIDTH : 6) + 1;
    localparam int ESW = ((ERR_CNT_WIDTH > 6) ? ERR_CNT_WIDTH : 6) + 1;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [30:0]              hist_q, hist_d;
    logic [4:0]               hist_fill_q, hist_fill_d;
    logic [30:0]              lfsr_q, lfsr_d;
    logic [7:0]               run_q, run_d;
    logic [7:0]               bad_q, bad_d;
    logic [2:0]               poly_q, poly_d;
    logic                     err_vld_q, err_vld_d;
    logic [DATA_W-1:0]        err_mask_q, err_mask_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic                     bit_full_q, bit_full_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     err_full_q, err_full_d;
    logic [7:0]               lock_loss_q, lock_loss_d;

    logic [4:0]               tap_n, tap_m;
    logic                     poly_chg;
    logic [30:0]              hunt_hist, ref_lfsr, seed_mask;
    logic [DATA_W-1:0]        hunt_err, lock_err;
    logic                     hunt_clean;
    logic [5:0]               err_pop;
    logic [6:0]               fill_sum;
    logic [BSW-1:0]           bit_sum;
    logic [ESW-1:0]           err_sum;
    logic [7:0]               run_inc, bad_inc;
    logic                     lock_hit, unlock_hit;

    // Polynomial x^n + x^m + 1 -> b[k] = b[k-n] ^ b[k-m]
    always_comb begin
        case (poly_sel)
            3'd1:    begin tap_n = 5'd9;  tap_m = 5'd5;  end
            3'd2:    begin tap_n = 5'd15; tap_m = 5'd14; end
            3'd3:    begin tap_n = 5'd23; tap_m = 5'd18; end
            3'd4:    begin tap_n = 5'd31; tap_m = 5'd28; end
            default: begin tap_n = 5'd7;  tap_m = 5'd6;  end
        endcase
    end

    // Bit predictions for the current word. Vectors are kept newest-in-bit-0,
    // so "n bits back" is index n-1. Bits are walked earliest first so later
    // bits of a word see the earlier ones.
    always_comb begin
        poly_chg  = (poly_sel != poly_q);
        seed_mask = 31'((32'd1 << tap_n) - 32'd1);

        hunt_hist = hist_q;
        hunt_err  = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            hunt_err[DATA_W-1-i] = din[DATA_W-1-i] ^ hunt_hist[tap_n-5'd1] ^ hunt_hist[tap_m-5'd1];
            hunt_hist            = {hunt_hist[29:0], din[DATA_W-1-i]};
        end

        // A zero seed would lock the LFSR at zero, so it counts as errored.
        hunt_clean = (hist_fill_q >= tap_n) && (hunt_err == '0) &&
                     ((hunt_hist & seed_mask) != '0);

        ref_lfsr = lfsr_q;
        lock_err = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            lock_err[DATA_W-1-i] = din[DATA_W-1-i] ^ ref_lfsr[tap_n-5'd1] ^ ref_lfsr[tap_m-5'd1];
            ref_lfsr             = {ref_lfsr[29:0], ref_lfsr[tap_n-5'd1] ^ ref_lfsr[tap_m-5'd1]};
        end

        err_pop = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            err_pop = err_pop + 6'(lock_err[i]);
        end

        fill_sum = 7'(hist_fill_q) + 7'(DATA_W);
        bit_sum  = BSW'(bit_cnt_q) + BSW'(DATA_W);
        err_sum  = ESW'(err_cnt_q) + ESW'(err_pop);
        run_inc  = run_q + 8'd1;
        bad_inc  = bad_q + 8'd1;
    end

    // Datapath next state
    always_comb begin
        hist_d      = hist_q;
        hist_fill_d = hist_fill_q;
        lfsr_d      = lfsr_q;
        run_d       = run_q;
        bad_d       = bad_q;
        poly_d      = poly_sel;
        err_vld_d   = 1'b0;
        err_mask_d  = err_mask_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        lock_loss_d = lock_loss_q;
        lock_hit    = 1'b0;
        unlock_hit  = 1'b0;

        if (poly_chg) begin
            // Word on a polynomial change is discarded: no history, no report.
            run_d       = '0;
            bad_d       = '0;
            hist_fill_d = '0;
        end else if (din_vld) begin
            err_vld_d   = 1'b1;
            hist_d      = hunt_hist;
            hist_fill_d = (fill_sum > 7'd31) ? 5'd31 : fill_sum[4:0];
            if (state_q == ST_HUNT) begin
                err_mask_d = hunt_err;
                if (!hunt_clean) begin
                    run_d = '0;
                end else if (run_inc == 8'(LOCK_CNT)) begin
                    lock_hit = 1'b1;
                    run_d    = '0;
                    bad_d    = '0;
                    lfsr_d   = hunt_hist & seed_mask;
                end else begin
                    run_d = run_inc;
                end
            end else begin
                err_mask_d = lock_err;
                lfsr_d     = ref_lfsr;
                bit_cnt_d  = (|bit_sum[BSW-1:BIT_CNT_WIDTH]) ? '1 : bit_sum[BIT_CNT_WIDTH-1:0];
                err_cnt_d  = (|err_sum[ESW-1:ERR_CNT_WIDTH]) ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
                if (lock_err == '0) begin
                    bad_d = '0;
                end else if (bad_inc == 8'(UNLOCK_CNT)) begin
                    unlock_hit  = 1'b1;
                    bad_d       = '0;
                    run_d       = '0;
                    hist_fill_d = '0;
                    if (lock_loss_q != 8'hFF) begin
                        lock_loss_d = lock_loss_q + 8'd1;
                    end
                end else begin
                    bad_d = bad_inc;
                end
            end
        end

        if (cnt_clr) begin
            bit_cnt_d   = '0;
            err_cnt_d   = '0;
            lock_loss_d = '0;
        end

        bit_full_d = &bit_cnt_d;
        err_full_d = &err_cnt_d;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (poly_chg) begin
            state_d = ST_HUNT;
        end else begin
            case (state_q)
                ST_HUNT:   if (lock_hit)   state_d = ST_LOCKED;
                ST_LOCKED: if (unlock_hit) state_d = ST_HUNT;
                default:   state_d = ST_HUNT;
            endcase
        end
    end

    // FSM/datapath outputs
    always_comb begin
        locked        = (state_q == ST_LOCKED);
        err_vld       = err_vld_q;
        err_mask      = err_mask_q;
        err_word      = |err_mask_q;
        bit_cnt       = bit_cnt_q;
        bit_cnt_full  = bit_full_q;
        err_cnt       = err_cnt_q;
        err_cnt_full  = err_full_q;
        lock_loss_cnt = lock_loss_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q      <= '0;
            hist_fill_q <= '0;
            lfsr_q      <= '0;
            run_q       <= '0;
            bad_q       <= '0;
            poly_q      <= '0;
            err_vld_q   <= 1'b0;
            err_mask_q  <= '0;
            bit_cnt_q   <= '0;
            bit_full_q  <= 1'b0;
            err_cnt_q   <= '0;
            err_full_q  <= 1'b0;
            lock_loss_q <= '0;
        end else begin
            hist_q      <= hist_d;
            hist_fill_q <= hist_fill_d;
            lfsr_q      <= lfsr_d;
            run_q       <= run_d;
            bad_q       <= bad_d;
            poly_q      <= poly_d;
            err_vld_q   <= err_vld_d;
            err_mask_q  <= err_mask_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_full_q  <= bit_full_d;
            err_cnt_q   <= err_cnt_d;
            err_full_q  <= err_full_d;
            lock_loss_q <= lock_loss_d;
        end
    end

endmodule

// File: tb/tb_prbs_chk_multi.sv
module tb_prbs_chk_multi;

    localparam int DW       = 8;
    localparam int BW       = 10;
    localparam int EW       = 4;
    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 4;
    localparam int BMAX     = (1 << BW) - 1;
    localparam int EMAX     = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    poly_sel;
    logic          cnt_clr;
    logic          din_vld;
    logic [DW-1:0] din;
    logic          locked;
    logic          err_vld;
    logic [DW-1:0] err_mask;
    logic          err_word;
    logic [BW-1:0] bit_cnt;
    logic          bit_cnt_full;
    logic [EW-1:0] err_cnt;
    logic          err_cnt_full;
    logic [7:0]    lock_loss_cnt;

    prbs_chk_multi #(
        .DATA_W       (DW),
        .BIT_CNT_WIDTH(BW),
        .ERR_CNT_WIDTH(EW),
        .LOCK_CNT     (LOCK_N),
        .UNLOCK_CNT   (UNLOCK_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .poly_sel     (poly_sel),
        .cnt_clr      (cnt_clr),
        .din_vld      (din_vld),
        .din          (din),
        .locked       (locked),
        .err_vld      (err_vld),
        .err_mask     (err_mask),
        .err_word     (err_word),
        .bit_cnt      (bit_cnt),
        .bit_cnt_full (bit_cnt_full),
        .err_cnt      (err_cnt),
        .err_cnt_full (err_cnt_full),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void taps(input int sel, output int n, output int m);
        case (sel)
            1:       begin n = 9;  m = 5;  end
            2:       begin n = 15; m = 14; end
            3:       begin n = 23; m = 18; end
            4:       begin n = 31; m = 28; end
            default: begin n = 7;  m = 6;  end
        endcase
    endfunction

    // ---------------- stream generator ----------------
    bit g_bits[$];
    int g_n, g_m;

    task automatic gen_start(input int sel);
        taps(sel, g_n, g_m);
        g_bits.delete();
    endtask

    task automatic gen_word(output logic [DW-1:0] w);
        bit b;
        for (int i = DW - 1; i >= 0; i--) begin
            if (g_bits.size() == 0)
                b = 1'b1;
            else if (g_bits.size() < g_n)
                b = 1'($urandom);
            else
                b = g_bits[g_bits.size() - g_n] ^ g_bits[g_bits.size() - g_m];
            g_bits.push_back(b);
            w[i] = b;
        end
        while (g_bits.size() > 64) g_bits.delete(0);
    endtask

    // ---------------- reference model ----------------
    // Received bits live in m_hist (oldest first, 31 deep); the locked
    // reference sequence grows in m_ref by the polynomial rule.
    bit            m_hist[$];
    bit            m_ref[$];
    int            m_locked, m_run, m_bad, m_fill, m_bitc, m_errc, m_loss, m_prev_poly;
    logic          m_err_vld;
    logic [DW-1:0] m_mask;

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_bad = 0; m_fill = 0;
        m_bitc = 0; m_errc = 0; m_loss = 0; m_prev_poly = 0;
        m_err_vld = 1'b0;
        m_mask = '0;
        m_hist.delete();
        repeat (31) m_hist.push_back(1'b0);
        m_ref.delete();
    endtask

    task automatic model_step(input logic vld, input logic [DW-1:0] d,
                              input logic [2:0] ps, input logic clr);
        int n, m;
        logic [DW-1:0] e;
        bit clean, seed_nz, p;
        taps(int'(ps), n, m);
        m_err_vld = 1'b0;
        e = '0;
        if (int'(ps) != m_prev_poly) begin
            m_locked = 0; m_run = 0; m_bad = 0; m_fill = 0;
        end else if (vld) begin
            m_err_vld = 1'b1;
            if (m_locked == 0) begin
                clean = (m_fill >= n);
                for (int i = DW - 1; i >= 0; i--) begin
                    p = m_hist[31 - n] ^ m_hist[31 - m];
                    e[i] = d[i] ^ p;
                    m_hist.push_back(d[i]);
                    m_hist.delete(0);
                end
                if (e != '0) clean = 1'b0;
                seed_nz = 1'b0;
                for (int k = 31 - n; k < 31; k++) seed_nz |= m_hist[k];
                if (!seed_nz) clean = 1'b0;
                m_fill = imin(m_fill + DW, 31);
                if (clean) begin
                    m_run++;
                    if (m_run == LOCK_N) begin
                        m_locked = 1; m_run = 0; m_bad = 0;
                        m_ref.delete();
                        for (int k = 31 - n; k < 31; k++) m_ref.push_back(m_hist[k]);
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                for (int i = DW - 1; i >= 0; i--) begin
                    p = m_ref[m_ref.size() - n] ^ m_ref[m_ref.size() - m];
                    m_ref.push_back(p);
                    e[i] = d[i] ^ p;
                    m_hist.push_back(d[i]);
                    m_hist.delete(0);
                end
                while (m_ref.size() > 40) m_ref.delete(0);
                m_fill = imin(m_fill + DW, 31);
                m_bitc = imin(m_bitc + DW, BMAX);
                m_errc = imin(m_errc + $countones(e), EMAX);
                if (e != '0) begin
                    m_bad++;
                    if (m_bad == UNLOCK_N) begin
                        m_locked = 0; m_bad = 0; m_run = 0; m_fill = 0;
                        m_loss = imin(m_loss + 1, 255);
                    end
                end else begin
                    m_bad = 0;
                end
            end
            m_mask = e;
        end
        m_prev_poly = int'(ps);
        if (clr) begin
            m_bitc = 0; m_errc = 0; m_loss = 0;
        end
    endtask

    task automatic check_outputs();
        check("locked",        64'(locked),        64'(m_locked));
        check("err_vld",       64'(err_vld),       64'(m_err_vld));
        check("err_mask",      64'(err_mask),      64'(m_mask));
        check("err_word",      64'(err_word),      64'(m_mask != '0));
        check("bit_cnt",       64'(bit_cnt),       64'(m_bitc));
        check("bit_cnt_full",  64'(bit_cnt_full),  64'(m_bitc == BMAX));
        check("err_cnt",       64'(err_cnt),       64'(m_errc));
        check("err_cnt_full",  64'(err_cnt_full),  64'(m_errc == EMAX));
        check("lock_loss_cnt", 64'(lock_loss_cnt), 64'(m_loss));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"},   64'(locked),        64'd0);
        check({tag, "_err_vld"},  64'(err_vld),       64'd0);
        check({tag, "_err_mask"}, 64'(err_mask),      64'd0);
        check({tag, "_err_word"}, 64'(err_word),      64'd0);
        check({tag, "_bit_cnt"},  64'(bit_cnt),       64'd0);
        check({tag, "_bit_full"}, 64'(bit_cnt_full),  64'd0);
        check({tag, "_err_cnt"},  64'(err_cnt),       64'd0);
        check({tag, "_err_full"}, 64'(err_cnt_full),  64'd0);
        check({tag, "_loss"},     64'(lock_loss_cnt), 64'd0);
    endtask

    task automatic cycle(input logic vld, input logic [DW-1:0] d,
                         input logic [2:0] ps, input logic clr);
        din_vld  = vld;
        din      = d;
        poly_sel = ps;
        cnt_clr  = clr;
        @(posedge clk);
        model_step(vld, d, ps, clr);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] flip;
        int vcount;

        rst = 1'b1; poly_sel = 3'd0; cnt_clr = 1'b0; din_vld = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // PRBS7: one filling word then four clean words lock
        gen_start(0);
        for (int k = 1; k <= 5; k++) begin
            gen_word(w);
            cycle(1'b1, w, 3'd0, 1'b0);
            if (k == 4) check("a_unlocked_w4", 64'(locked), 64'd0);
        end
        check("a_locked_w5", 64'(locked), 64'd1);
        for (int k = 0; k < 100; k++) begin
            gen_word(w);
            cycle(1'b1, w, 3'd0, 1'b0);
        end
        check("a_bit_cnt_800", 64'(bit_cnt), 64'd800);
        check("a_err_cnt_0",   64'(err_cnt), 64'd0);

        // Single flipped bit
        gen_word(w);
        cycle(1'b1, w ^ 8'h08, 3'd0, 1'b0);
        check("b_mask_08",  64'(err_mask), 64'h08);
        check("b_vld",      64'(err_vld),  64'd1);
        check("b_err_cnt1", 64'(err_cnt),  64'd1);
        gen_word(w);
        cycle(1'b1, w, 3'd0, 1'b0);
        check("b_mask_clr", 64'(err_mask), 64'd0);
        check("b_locked",   64'(locked),   64'd1);

        // Clear wins over a simultaneous update; then four errored words unlock
        gen_word(w);
        cycle(1'b1, w, 3'd0, 1'b1);
        check("c_clr_bit", 64'(bit_cnt), 64'd0);
        check("c_clr_err", 64'(err_cnt), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            gen_word(w);
            flip = 8'd1 << $urandom_range(0, 7);
            cycle(1'b1, w ^ flip, 3'd0, 1'b0);
            if (k == 3) check("c_still_locked", 64'(locked), 64'd1);
        end
        check("c_unlocked", 64'(locked),        64'd0);
        check("c_loss1",    64'(lock_loss_cnt), 64'd1);
        check("c_err4",     64'(err_cnt),       64'd4);
        for (int k = 1; k <= 5; k++) begin
            gen_word(w);
            cycle(1'b1, w, 3'd0, 1'b0);
            if (k == 4) check("c_relock_w4", 64'(locked), 64'd0);
        end
        check("c_relock_w5", 64'(locked), 64'd1);

        // Saturation of both counters
        cycle(1'b0, '0, 3'd0, 1'b1);
        for (int k = 0; k < 130; k++) begin
            gen_word(w);
            cycle(1'b1, w, 3'd0, 1'b0);
        end
        check("d_bit_sat",  64'(bit_cnt),      64'd1023);
        check("d_bit_full", 64'(bit_cnt_full), 64'd1);
        for (int k = 0; k < 4; k++) begin
            gen_word(w);
            cycle(1'b1, ~w, 3'd0, 1'b0);
        end
        check("d_err_sat",  64'(err_cnt),       64'd15);
        check("d_err_full", 64'(err_cnt_full),  64'd1);
        check("d_unlocked", 64'(locked),        64'd0);
        check("d_loss1",    64'(lock_loss_cnt), 64'd1);
        cycle(1'b0, '0, 3'd0, 1'b1);
        check("d_clr_bit",  64'(bit_cnt),       64'd0);
        check("d_clr_bf",   64'(bit_cnt_full),  64'd0);
        check("d_clr_err",  64'(err_cnt),       64'd0);
        check("d_clr_ef",   64'(err_cnt_full),  64'd0);

        // PRBS31 with random gaps in din_vld
        gen_start(4);
        cycle(1'b0, '0, 3'd4, 1'b0);
        vcount = 0;
        for (int c = 0; c < 120; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_word(w);
                cycle(1'b1, w, 3'd4, 1'b0);
                vcount++;
                if (vcount == 7) check("e_unlocked_w7", 64'(locked), 64'd0);
                if (vcount == 8) check("e_locked_w8",   64'(locked), 64'd1);
            end else begin
                cycle(1'b0, 8'($urandom), 3'd4, 1'b0);
            end
        end
        check("e_bit_cnt", 64'(bit_cnt), 64'(8 * (vcount - 8)));
        check("e_err_0",   64'(err_cnt), 64'd0);

        // Switch to PRBS15 mid-stream
        gen_start(2);
        cycle(1'b0, '0, 3'd2, 1'b0);
        check("e_switch_unlock", 64'(locked),        64'd0);
        check("e_switch_loss",   64'(lock_loss_cnt), 64'd0);
        for (int k = 1; k <= 6; k++) begin
            gen_word(w);
            cycle(1'b1, w, 3'd2, 1'b0);
            if (k == 5) check("e15_unlocked_w5", 64'(locked), 64'd0);
        end
        check("e15_locked_w6", 64'(locked), 64'd1);

        // Async reset between edges while locked, then an all-zero stream
        for (int k = 0; k < 3; k++) begin
            gen_word(w);
            cycle(1'b1, w, 3'd2, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        check_zero("f_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("f_held");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            cycle(1'b1, '0, 3'd2, 1'b0);
        end
        check("f_zero_never_locks", 64'(locked), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
